// File: rtl/mmult_stream_ctrl_if.sv
// Purpose : bundles the host operand stream, result stream, status flags and
//           the datapath-side bus of the 3x3 matrix-multiply sequencer.
// Ports   : in_valid/in_ready/in_data (operand bytes), out_valid/out_ready/
//           out_data/out_last (results), busy/err (status), mm_enable/
//           mm_a_mat/mm_b_mat/mm_valid/mm_c_mat (datapath).
// master is the controller view; slave is the host + datapath view.
interface mmult_stream_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         out_valid;
  logic         out_ready;
  logic [16:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         err;
  logic         mm_enable;
  logic [71:0]  mm_a_mat;
  logic [71:0]  mm_b_mat;
  logic         mm_valid;
  logic [152:0] mm_c_mat;

  modport master (
    input  in_valid, in_data, out_ready, mm_valid, mm_c_mat,
    output in_ready, out_valid, out_data, out_last, busy, err,
           mm_enable, mm_a_mat, mm_b_mat
  );

  modport slave (
    output in_valid, in_data, out_ready, mm_valid, mm_c_mat,
    input  in_ready, out_valid, out_data, out_last, busy, err,
           mm_enable, mm_a_mat, mm_b_mat
  );
endinterface

// File: rtl/mmult_stream_ctrl.sv
// Purpose : sequencer for the 3x3 matmul datapath: loads 18 operand bytes
//           (A then B, row-major), runs the datapath, streams 9 results out.
// Latency : last byte accepted at E0, datapath samples at E1, results captured
//           at E2; out_valid high after E2 (minimum job 18+2+9 cycles).
// Backpressure: out_data holds while out_valid && !out_ready; no input is
//           accepted during RUN/DRAIN (in_ready low).
// Ports   : clk, reset_n (synchronous, active-low), bus (mmult_stream_ctrl_if
//           master: operand stream, result stream, busy/err, datapath bus).
// Option  : MMULT_CTRL_TIMEOUT_EN adds a RUN timeout of TIMEOUT_CYC cycles
//           that sets the sticky err flag and aborts the job.
module mmult_stream_ctrl #(
  parameter int TIMEOUT_CYC   = 16,
  parameter bit OUT_COL_MAJOR = 1'b0
) (
  input logic                 clk,
  input logic                 reset_n,
  mmult_stream_ctrl_if.master bus
);
  localparam int RUN_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) + 1 : 2;

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DRAIN} state_t;

  state_t           state, state_nxt;
  logic [4:0]       byte_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [3:0]       idx;
  logic [3:0]       sel;
  logic [0:8][7:0]  a_q, b_q;
  logic [0:8][16:0] res_q;

  logic in_rdy, out_vld, out_lst, mm_en, busy_o;
  logic in_fire, out_fire, mm_hit, timeout, err_o;

  assign in_fire  = in_rdy && bus.in_valid;
  assign out_fire = out_vld && bus.out_ready;
  // run_cnt==0 masks a valid still asserted from the previous job's last cycle.
  assign mm_hit   = (state == ST_RUN) && bus.mm_valid && (run_cnt != '0);

`ifdef MMULT_CTRL_TIMEOUT_EN
  logic err_q;
  // run_cnt holds k-1 at the k-th RUN edge, so this fires on the last allowed cycle.
  assign timeout = (state == ST_RUN) && !mm_hit && (run_cnt == RUN_W'(TIMEOUT_CYC - 1));
  assign err_o   = err_q;

  always_ff @(posedge clk) begin
    if (!reset_n)     err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Output order: row-major passes idx through; column-major transposes it.
  always_comb begin
    sel = idx;
    if (OUT_COL_MAJOR) begin
      case (idx)
        4'd1:    sel = 4'd3;
        4'd2:    sel = 4'd6;
        4'd3:    sel = 4'd1;
        4'd5:    sel = 4'd7;
        4'd6:    sel = 4'd2;
        4'd7:    sel = 4'd5;
        default: sel = idx;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    out_lst   = 1'b0;
    mm_en     = 1'b0;
    busy_o    = 1'b0;
    case (state)
      ST_LOAD: begin
        in_rdy = 1'b1;
        if (in_fire && byte_cnt == 5'd17) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        mm_en  = 1'b1;
        busy_o = 1'b1;
        if (mm_hit)       state_nxt = ST_DRAIN;
        else if (timeout) state_nxt = ST_LOAD;
      end
      ST_DRAIN: begin
        out_vld = 1'b1;
        busy_o  = 1'b1;
        out_lst = (idx == 4'd8);
        if (out_fire && idx == 4'd8) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_LOAD;
      byte_cnt <= '0;
      run_cnt  <= '0;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        if (byte_cnt < 5'd9) a_q[byte_cnt[3:0]] <= bus.in_data;
        else                 b_q[4'(byte_cnt - 5'd9)] <= bus.in_data;
        byte_cnt <= (byte_cnt == 5'd17) ? 5'd0 : byte_cnt + 5'd1;
      end
      if (state == ST_RUN) begin
        if (mm_hit || timeout)   run_cnt <= '0;
        else if (run_cnt != '1)  run_cnt <= run_cnt + 1'b1;
      end
      if (mm_hit) res_q <= bus.mm_c_mat;
      if (out_fire) idx <= (idx == 4'd8) ? 4'd0 : idx + 4'd1;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_last  = out_lst;
  assign bus.out_data  = out_vld ? res_q[sel] : 17'd0;
  assign bus.mm_enable = mm_en;
  assign bus.busy      = busy_o;
  assign bus.err       = err_o;
  assign bus.mm_a_mat  = a_q;
  assign bus.mm_b_mat  = b_q;
endmodule

// File: tb/tb_mmult_stream_ctrl.sv
// Purpose : directed bench for mmult_stream_ctrl; a row-major and a column-major
//           instance receive identical stimulus, each with a behavioural datapath.
// Ports   : none (top-level bench).
module tb_mmult_stream_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stub = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mmult_stream_ctrl_if br();
  mmult_stream_ctrl_if bc();

  mmult_stream_ctrl #(.TIMEOUT_CYC(16), .OUT_COL_MAJOR(1'b0)) u_row (
    .clk(clk), .reset_n(reset_n), .bus(br)
  );
  mmult_stream_ctrl #(.TIMEOUT_CYC(16), .OUT_COL_MAJOR(1'b1)) u_col (
    .clk(clk), .reset_n(reset_n), .bus(bc)
  );

  // Behavioural datapath: samples operands when enabled, result valid one cycle later.
  function automatic logic [152:0] mmul(input logic [71:0] a, input logic [71:0] b);
    logic [0:8][7:0]  aa, bb;
    logic [0:8][16:0] cc;
    logic [31:0]      s;
    aa = a;
    bb = b;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 32'd0;
        for (int k = 0; k < 3; k++) s = s + 32'(aa[i*3+k]) * 32'(bb[k*3+j]);
        cc[i*3+j] = s[16:0];
      end
    return cc;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      br.mm_valid <= 1'b0;
      bc.mm_valid <= 1'b0;
      br.mm_c_mat <= '0;
      bc.mm_c_mat <= '0;
    end else begin
      br.mm_valid <= br.mm_enable && !stub;
      bc.mm_valid <= bc.mm_enable && !stub;
      br.mm_c_mat <= mmul(br.mm_a_mat, br.mm_b_mat);
      bc.mm_c_mat <= mmul(bc.mm_a_mat, bc.mm_b_mat);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input logic v, input logic [7:0] d);
    br.in_valid = v; bc.in_valid = v;
    br.in_data  = d; bc.in_data  = d;
  endtask

  task automatic set_rdy(input logic r);
    br.out_ready = r;
    bc.out_ready = r;
  endtask

  // Ends at the negedge just after the final byte's accepting edge.
  task automatic load_job(input logic [0:8][7:0] a, input logic [0:8][7:0] b);
    int guard;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      guard = 0;
      while (!(br.in_ready && bc.in_ready) && guard < 50) begin
        set_in(1'b0, 8'd0);
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) chk("in_ready_timeout", 32'(guard), 32'd0);
      set_in(1'b1, (k < 9) ? a[k] : b[k-9]);
    end
    @(negedge clk);
    set_in(1'b0, 8'd0);
  endtask

  // Called at a negedge; stall=1 offers out_ready only every third cycle.
  task automatic collect(input logic [0:8][16:0] er, input logic [0:8][16:0] ec, input bit stall);
    int   n;
    int   cyc;
    logic rdy;
    n = 0;
    cyc = 0;
    while (n < 9 && cyc < 200) begin
      rdy = !stall || (cyc % 3 == 0);
      chk("row_valid", 32'(br.out_valid), 32'd1);
      chk("col_valid", 32'(bc.out_valid), 32'd1);
      chk("row_data", 32'(br.out_data), 32'(er[n]));
      chk("col_data", 32'(bc.out_data), 32'(ec[n]));
      chk("row_last", 32'(br.out_last), 32'(n == 8));
      chk("col_last", 32'(bc.out_last), 32'(n == 8));
      set_rdy(rdy);
      if (br.out_valid && rdy) n++;
      @(negedge clk);
      cyc++;
    end
    chk("collect_count", 32'(n), 32'd9);
    set_rdy(1'b0);
    chk("post_valid", 32'(br.out_valid), 32'd0);
    chk("post_busy", 32'(br.busy), 32'd0);
    chk("post_in_ready", 32'(br.in_ready), 32'd1);
  endtask

  logic [0:8][7:0]  a_id  = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
  logic [0:8][7:0]  b_seq = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
  logic [0:8][7:0]  b_rev = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  logic [0:8][7:0]  a_ff  = {9{8'hFF}};
  logic [0:8][16:0] e_row = {17'd1, 17'd2, 17'd3, 17'd4, 17'd5, 17'd6, 17'd7, 17'd8, 17'd9};
  logic [0:8][16:0] e_col = {17'd1, 17'd4, 17'd7, 17'd2, 17'd5, 17'd8, 17'd3, 17'd6, 17'd9};
  logic [0:8][16:0] e_ff  = {9{17'h0FA03}};
  logic [0:8][16:0] e4_row = {17'd30, 17'd24, 17'd18, 17'd84, 17'd69, 17'd54, 17'd138, 17'd114, 17'd90};
  logic [0:8][16:0] e4_col = {17'd30, 17'd84, 17'd138, 17'd24, 17'd69, 17'd114, 17'd18, 17'd54, 17'd90};

  initial begin
    set_in(1'b0, 8'd0);
    set_rdy(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(br.in_ready), 32'd1);
    chk("rst_out_valid", 32'(br.out_valid), 32'd0);
    chk("rst_out_last", 32'(br.out_last), 32'd0);
    chk("rst_out_data", 32'(br.out_data), 32'd0);
    chk("rst_mm_enable", 32'(br.mm_enable), 32'd0);
    chk("rst_busy", 32'(br.busy), 32'd0);
    chk("rst_err", 32'(br.err), 32'd0);
    reset_n = 1'b1;

    // Identity times 1..9, with latency checks around E0/E1/E2.
    load_job(a_id, b_seq);
    chk("e0_in_ready", 32'(br.in_ready), 32'd0);
    chk("e0_mm_enable", 32'(br.mm_enable), 32'd1);
    chk("e0_busy", 32'(br.busy), 32'd1);
    chk("e0_out_valid", 32'(br.out_valid), 32'd0);
    chk("a_operands", 32'(br.mm_a_mat[71:64]), 32'd1);
    chk("b_last_operand", 32'(br.mm_b_mat[7:0]), 32'd9);
    @(negedge clk);
    chk("e1_out_valid", 32'(br.out_valid), 32'd0);
    chk("e1_mm_enable", 32'(br.mm_enable), 32'd1);
    @(negedge clk);
    chk("e2_out_valid", 32'(br.out_valid), 32'd1);
    chk("e2_mm_enable", 32'(br.mm_enable), 32'd0);
    collect(e_row, e_col, 1'b0);
    chk("job1_err", 32'(br.err), 32'd0);

    // All 255: 3*255*255 wraps to 0x0FA03.
    load_job(a_ff, a_ff);
    repeat (2) @(negedge clk);
    collect(e_ff, e_ff, 1'b0);

    // Stalled sink: data must hold while not accepted.
    load_job(b_seq, b_rev);
    repeat (2) @(negedge clk);
    collect(e4_row, e4_col, 1'b1);

    // Reset in the middle of DRAIN at idx 4.
    load_job(a_id, b_seq);
    repeat (2) @(negedge clk);
    set_rdy(1'b1);
    repeat (4) @(negedge clk);
    chk("mid_row_data", 32'(br.out_data), 32'd5);
    chk("mid_col_data", 32'(bc.out_data), 32'd5);
    set_rdy(1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_out_valid", 32'(br.out_valid), 32'd0);
    chk("abort_in_ready", 32'(br.in_ready), 32'd1);
    chk("abort_busy", 32'(bc.busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_no_output", 32'(br.out_valid || bc.out_valid), 32'd0);
    load_job(a_id, b_seq);
    repeat (2) @(negedge clk);
    collect(e_row, e_col, 1'b0);

    // Datapath silent.
    stub = 1'b1;
    load_job(a_id, b_seq);
`ifdef MMULT_CTRL_TIMEOUT_EN
    repeat (15) @(negedge clk);
    chk("to_busy_before", 32'(br.busy), 32'd1);
    chk("to_err_before", 32'(br.err), 32'd0);
    @(negedge clk);
    chk("to_err", 32'(br.err), 32'd1);
    chk("to_mm_enable", 32'(br.mm_enable), 32'd0);
    chk("to_in_ready", 32'(br.in_ready), 32'd1);
    chk("to_out_valid", 32'(br.out_valid), 32'd0);
    stub = 1'b0;
    load_job(a_id, b_seq);
    repeat (2) @(negedge clk);
    collect(e_row, e_col, 1'b0);
    chk("to_err_sticky", 32'(br.err), 32'd1);
`else
    repeat (40) @(negedge clk);
    chk("hang_busy", 32'(br.busy), 32'd1);
    chk("hang_mm_enable", 32'(br.mm_enable), 32'd1);
    chk("hang_err", 32'(br.err), 32'd0);
    chk("hang_out_valid", 32'(br.out_valid), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    stub = 1'b0;
    chk("hang_reset_in_ready", 32'(br.in_ready), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
